// File: rtl/bcd_score_tracker.sv
// Game score tracker: a binary score and a packed BCD image kept in lockstep.
// The score ticks up while running, drops on collision edges and saturates at both ends.
module bcd_score_tracker #(
  parameter int DIGITS      = 2,
  parameter int TICK_CYCLES = 60_000_000,
  parameter int START_SCORE = 10,
  parameter int MAX_SCORE   = 99,
  parameter int PENALTY     = 1,
  parameter int SCORE_W     = $clog2(MAX_SCORE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            state,
  input  logic                  collision_detect,
  output logic [SCORE_W-1:0]    score_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  tick_o,
  output logic                  at_max_o,
  output logic                  at_zero_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam int SUM_W = SCORE_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WIN = 2'd2, OVER = 2'd3} state_t;

  function automatic logic [BCD_W-1:0] to_bcd(input int value);
    int v;
    logic [BCD_W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit-serial add: a digit sum above 9 is corrected by +6 and carries.
  function automatic logic [BCD_W-1:0] bcd_add(input logic [BCD_W-1:0] a,
                                                input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [4:0] s;
    logic c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return r;
  endfunction

  // Digit-serial subtract: a negative digit difference is corrected by -6 and borrows.
  function automatic logic [BCD_W-1:0] bcd_sub(input logic [BCD_W-1:0] a,
                                                input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [4:0] d;
    logic bw;
    r = '0;
    bw = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, bw};
      if (d[4]) begin
        d = d - 5'd6;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0]        START_BCD = to_bcd(START_SCORE);
  localparam logic [BCD_W-1:0]        MAX_BCD   = to_bcd(MAX_SCORE);
  localparam logic [BCD_W-1:0]        ONE_BCD   = to_bcd(1);
  localparam logic [BCD_W-1:0]        PEN_BCD   = to_bcd(PENALTY);
  localparam logic [BCD_W-1:0]        NET_BCD   = to_bcd(PENALTY - 1);
  localparam logic signed [SUM_W-1:0] MAX_S     = SUM_W'(MAX_SCORE);
  localparam logic signed [SUM_W-1:0] PEN_S     = SUM_W'(PENALTY);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TICK_CYCLES - 1);

  state_t                   st;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     col_q;
  logic                     det, tick;
  logic signed [SUM_W-1:0]  inc, dec, sum;
  logic [BCD_W-1:0]         bcd_step, bcd_d;
  logic [SCORE_W-1:0]       score_d;

  assign st = state_t'(state);

  always_comb begin
    det      = collision_detect & ~col_q;
    tick     = (st == RUN) && (cnt_q == CNT_LAST);
    inc      = tick ? SUM_W'(1) : '0;
    dec      = det ? PEN_S : '0;
    sum      = $signed({2'b00, score_o}) + inc - dec;
    bcd_step = bcd_o;
    case ({tick, det})
      2'b10:   bcd_step = bcd_add(bcd_o, ONE_BCD);
      2'b01:   bcd_step = bcd_sub(bcd_o, PEN_BCD);
      2'b11:   bcd_step = bcd_sub(bcd_o, NET_BCD);
      default: bcd_step = bcd_o;
    endcase

    cnt_d   = cnt_q;
    score_d = score_o;
    bcd_d   = bcd_o;
    case (st)
      RUN: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (sum[SUM_W-1]) begin
          score_d = '0;
          bcd_d   = '0;
        end else if (sum > MAX_S) begin
          score_d = SCORE_W'(MAX_SCORE);
          bcd_d   = MAX_BCD;
        end else begin
          score_d = sum[SCORE_W-1:0];
          bcd_d   = bcd_step;
        end
      end
      WIN, OVER: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d   = '0;
        score_d = SCORE_W'(START_SCORE);
        bcd_d   = START_BCD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      col_q   <= 1'b0;
      score_o <= SCORE_W'(START_SCORE);
      bcd_o   <= START_BCD;
      tick_o  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      col_q   <= collision_detect;
      score_o <= score_d;
      bcd_o   <= bcd_d;
      tick_o  <= tick;
    end
  end

  assign at_max_o  = (score_o == SCORE_W'(MAX_SCORE));
  assign at_zero_o = (score_o == '0);

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Bench for bcd_score_tracker: two instances (penalty 1 and 3, 4-cycle tick),
// a vector table, directed corner sequences and a randomized run against an integer model.
module tb_bcd_score_tracker;

  localparam int T     = 4;
  localparam int START = 10;
  localparam int MAXS  = 99;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WIN  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic       clk, reset;
  logic [1:0] state_a, state_b;
  logic       col_a, col_b;
  logic [6:0] score_a, score_b;
  logic [7:0] bcd_a, bcd_b;
  logic       tick_a, tick_b, max_a, max_b, zero_a, zero_b;

  bcd_score_tracker #(.DIGITS(2), .TICK_CYCLES(T), .START_SCORE(START), .MAX_SCORE(MAXS),
                      .PENALTY(1)) dut_a (
    .clk(clk), .reset(reset), .state(state_a), .collision_detect(col_a),
    .score_o(score_a), .bcd_o(bcd_a), .tick_o(tick_a), .at_max_o(max_a), .at_zero_o(zero_a));

  bcd_score_tracker #(.DIGITS(2), .TICK_CYCLES(T), .START_SCORE(START), .MAX_SCORE(MAXS),
                      .PENALTY(3)) dut_b (
    .clk(clk), .reset(reset), .state(state_b), .collision_detect(col_b),
    .score_o(score_b), .bcd_o(bcd_b), .tick_o(tick_b), .at_max_o(max_b), .at_zero_o(zero_b));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   m_score[2];
  int   m_cnt[2];
  logic m_col[2];
  logic m_tick[2];

  task automatic model_step(input int i, input logic [1:0] st, input logic col, input int pen);
    bit d, t;
    d = col && !m_col[i];
    m_col[i] = col;
    t = 1'b0;
    case (st)
      S_RUN: begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == T) begin
          m_cnt[i] = 0;
          t = 1'b1;
        end
        m_score[i] = m_score[i] + (t ? 1 : 0) - (d ? pen : 0);
        if (m_score[i] < 0) m_score[i] = 0;
        if (m_score[i] > MAXS) m_score[i] = MAXS;
      end
      S_WIN, S_OVER: ;
      default: begin
        m_cnt[i] = 0;
        m_score[i] = START;
      end
    endcase
    m_tick[i] = t;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_score[i] = START;
        m_cnt[i] = 0;
        m_col[i] = 1'b0;
        m_tick[i] = 1'b0;
      end
    end else begin
      model_step(0, state_a, col_a, 1);
      model_step(1, state_b, col_b, 3);
    end
  end

  function automatic logic [7:0] dec_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp_model();
    exp_q.push_back(32'(m_score[0]));
    exp_q.push_back(32'(m_score[1]));
    chk("rnd score_a", {25'd0, score_a}, exp_q.pop_front());
    chk("rnd score_b", {25'd0, score_b}, exp_q.pop_front());
    chk("rnd bcd_a", {24'd0, bcd_a}, {24'd0, dec_bcd(m_score[0])});
    chk("rnd bcd_b", {24'd0, bcd_b}, {24'd0, dec_bcd(m_score[1])});
    chk("rnd tick_a", {31'd0, tick_a}, {31'd0, m_tick[0]});
    chk("rnd tick_b", {31'd0, tick_b}, {31'd0, m_tick[1]});
    chk("rnd max_a", {31'd0, max_a}, {31'd0, m_score[0] == MAXS});
    chk("rnd zero_b", {31'd0, zero_b}, {31'd0, m_score[1] == 0});
  endtask

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] sa, input logic ca, input logic [1:0] sb, input logic cb);
    state_a = sa;
    col_a   = ca;
    state_b = sb;
    col_b   = cb;
  endtask

  typedef struct {
    logic [1:0] st;
    logic       col;
    int         score;
    logic [7:0] bcd;
    logic       tick;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int k, n;
    logic cols[11];

    tbl[0]  = '{S_IDLE, 1'b0, 10, 8'h10, 1'b0};
    tbl[1]  = '{S_RUN,  1'b1,  9, 8'h09, 1'b0};
    tbl[2]  = '{S_RUN,  1'b1,  9, 8'h09, 1'b0};
    tbl[3]  = '{S_RUN,  1'b1,  9, 8'h09, 1'b0};
    tbl[4]  = '{S_RUN,  1'b0, 10, 8'h10, 1'b1};
    tbl[5]  = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[6]  = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[7]  = '{S_RUN,  1'b1,  9, 8'h09, 1'b0};
    tbl[8]  = '{S_RUN,  1'b0, 10, 8'h10, 1'b1};
    tbl[9]  = '{S_WIN,  1'b0, 10, 8'h10, 1'b0};
    tbl[10] = '{S_OVER, 1'b1, 10, 8'h10, 1'b0};
    tbl[11] = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[12] = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[13] = '{S_RUN,  1'b1,  9, 8'h09, 1'b0};
    tbl[14] = '{S_RUN,  1'b1, 10, 8'h10, 1'b1};
    tbl[15] = '{S_OVER, 1'b0, 10, 8'h10, 1'b0};
    tbl[16] = '{S_IDLE, 1'b0, 10, 8'h10, 1'b0};
    tbl[17] = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[18] = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[19] = '{S_RUN,  1'b0, 10, 8'h10, 1'b0};
    tbl[20] = '{S_RUN,  1'b1, 10, 8'h10, 1'b1};

    reset = 1'b0;
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst score_a", {25'd0, score_a}, 32'd10);
    chk("rst bcd_a", {24'd0, bcd_a}, 32'h10);
    chk("rst zero_a", {31'd0, zero_a}, 32'd0);
    chk("rst tick_a", {31'd0, tick_a}, 32'd0);
    chk("rst max_a", {31'd0, max_a}, 32'd0);
    chk("rst score_b", {25'd0, score_b}, 32'd10);
    chk("rst bcd_b", {24'd0, bcd_b}, 32'h10);
    reset = 1'b1;

    // Vector table on the penalty-1 instance.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].st, tbl[i].col, S_IDLE, 1'b0);
      cyc();
      chk($sformatf("tbl[%0d] score", i), {25'd0, score_a}, 32'(tbl[i].score));
      chk($sformatf("tbl[%0d] bcd", i), {24'd0, bcd_a}, {24'd0, tbl[i].bcd});
      chk($sformatf("tbl[%0d] tick", i), {31'd0, tick_a}, {31'd0, tbl[i].tick});
    end

    // Saturation at the ceiling; ticks keep pulsing.
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    cyc();
    drive(S_RUN, 1'b0, S_IDLE, 1'b0);
    repeat (95 * T) cyc();
    chk("sat score", {25'd0, score_a}, 32'd99);
    chk("sat bcd", {24'd0, bcd_a}, 32'h99);
    chk("sat at_max", {31'd0, max_a}, 32'd1);
    n = 0;
    repeat (40) begin
      cyc();
      if (tick_a) n++;
    end
    chk("sat tick count", 32'(n), 32'd10);
    chk("sat hold", {25'd0, score_a}, 32'd99);

    // Collision held high counts once.
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    cyc();
    drive(S_RUN, 1'b1, S_IDLE, 1'b0);
    cyc();
    chk("held first score", {25'd0, score_a}, 32'd9);
    chk("held first bcd", {24'd0, bcd_a}, 32'h09);
    repeat (19) cyc();
    chk("held end score", {25'd0, score_a}, 32'd14);
    chk("held end bcd", {24'd0, bcd_a}, 32'h14);

    // Penalty 3 driven down to the floor.
    cols = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    cyc();
    for (int i = 0; i < 11; i++) begin
      drive(S_IDLE, 1'b0, S_RUN, cols[i]);
      cyc();
      if (i == 4) chk("p3 at two", {25'd0, score_b}, 32'd2);
      if (i == 6) begin
        chk("p3 clamp score", {25'd0, score_b}, 32'd0);
        chk("p3 clamp bcd", {24'd0, bcd_b}, 32'h00);
        chk("p3 clamp zero", {31'd0, zero_b}, 32'd1);
      end
    end
    chk("p3 zero hold", {25'd0, score_b}, 32'd0);
    chk("p3 zero flag", {31'd0, zero_b}, 32'd1);

    // Tick and collision edge on the same cycle at 40.
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    cyc();
    drive(S_RUN, 1'b0, S_RUN, 1'b0);
    repeat (30 * T) cyc();
    chk("net a start", {25'd0, score_a}, 32'd40);
    chk("net b start", {25'd0, score_b}, 32'd40);
    repeat (T - 1) cyc();
    drive(S_RUN, 1'b1, S_RUN, 1'b1);
    cyc();
    chk("net a score", {25'd0, score_a}, 32'd40);
    chk("net a tick", {31'd0, tick_a}, 32'd1);
    chk("net b score", {25'd0, score_b}, 32'd38);
    chk("net b bcd", {24'd0, bcd_b}, 32'h38);

    // Freeze in OVER mid-interval, then IDLE restarts the counter.
    drive(S_RUN, 1'b0, S_IDLE, 1'b0);
    repeat (2) cyc();
    drive(S_OVER, 1'b0, S_IDLE, 1'b0);
    repeat (10) cyc();
    chk("over score", {25'd0, score_a}, 32'd40);
    chk("over tick", {31'd0, tick_a}, 32'd0);
    drive(S_RUN, 1'b0, S_IDLE, 1'b0);
    cyc();
    chk("resume no tick", {31'd0, tick_a}, 32'd0);
    cyc();
    chk("resume tick", {31'd0, tick_a}, 32'd1);
    chk("resume score", {25'd0, score_a}, 32'd41);
    drive(S_IDLE, 1'b0, S_IDLE, 1'b0);
    cyc();
    chk("idle score", {25'd0, score_a}, 32'd10);
    drive(S_RUN, 1'b0, S_IDLE, 1'b0);
    repeat (T - 1) cyc();
    chk("idle cnt cleared", {31'd0, tick_a}, 32'd0);
    cyc();
    chk("idle first tick", {25'd0, score_a}, 32'd11);

    // Async reset mid-interval restarts the tick interval.
    repeat (2) cyc();
    #2 reset = 1'b0;
    #1;
    chk("async score", {25'd0, score_a}, 32'd10);
    chk("async tick", {31'd0, tick_a}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      k++;
      if (tick_a) break;
    end
    chk("async first tick edge", 32'(k), 32'(T));

    // Randomized run against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) state_a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : S_RUN;
      if ($urandom_range(0, 19) == 0) state_b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : S_RUN;
      if ($urandom_range(0, 2) == 0) col_a = ~col_a;
      if ($urandom_range(0, 3) == 0) col_b = ~col_b;
      cyc();
      cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
